// File: rtl/mux_nto1_scan.sv
// rtl/mux_nto1_scan.sv - N-to-1 registered mux with manual select and auto-scan modes
module mux_nto1_scan #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int DWELL = 2,
    localparam int SW   = (N <= 2) ? 1 : $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] D,
    input  logic [SW-1:0]  Sel,
    input  logic           mode,
    input  logic           en,
    output logic [W-1:0]   Y,
    output logic [SW-1:0]  Y_sel,
    output logic           Y_valid,
    input  logic           Y_ready,
    output logic           Y_err,
    output logic           wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAN  = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic [SW:0]  N_L       = (SW + 1)'(N);
    localparam logic [SW-1:0] CH_LAST  = SW'(N - 1);
    localparam logic [7:0]   DWELL_LAST = 8'(DWELL - 1);

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   ch_cnt;
    logic [7:0]      dwell_cnt;
    logic            capture;
    logic            sel_ok;
    logic            dwell_last;
    logic            ch_last;
    logic [W-1:0]    man_data;
    logic [W-1:0]    scan_data;

    // Target state follows en/mode directly every cycle
    always_comb begin
        state_nxt = IDLE;
        if (en) begin
            state_nxt = mode ? SCAN : MAN;
        end
    end

    // A new sample is taken whenever enabled and the output slot is free or being drained
    always_comb begin
        capture    = (state_nxt != IDLE) && (!Y_valid || Y_ready);
        sel_ok     = {1'b0, Sel} < N_L;
        dwell_last = (dwell_cnt == DWELL_LAST);
        ch_last    = (ch_cnt == CH_LAST);
    end

    // Channel extraction for the manual select and the scan pointer
    always_comb begin
        man_data  = '0;
        scan_data = '0;
        for (int k = 0; k < N; k++) begin
            if (Sel == SW'(k)) begin
                man_data = D[k*W +: W];
            end
            if (ch_cnt == SW'(k)) begin
                scan_data = D[k*W +: W];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Scan pointer: held at zero outside SCAN so every entry starts at channel 0,
    // frozen while stalled, advanced once per scan capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt    <= '0;
            dwell_cnt <= '0;
        end else if (state_nxt != SCAN) begin
            ch_cnt    <= '0;
            dwell_cnt <= '0;
        end else if (capture) begin
            if (dwell_last) begin
                dwell_cnt <= '0;
                ch_cnt    <= ch_last ? '0 : ch_cnt + 1'b1;
            end else begin
                dwell_cnt <= dwell_cnt + 8'd1;
            end
        end
    end

    // Output sample register with valid/ready hold and the one-cycle wrap marker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y       <= '0;
            Y_sel   <= '0;
            Y_valid <= 1'b0;
            Y_err   <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (capture) begin
                Y_valid <= 1'b1;
                if (state_nxt == SCAN) begin
                    Y     <= scan_data;
                    Y_sel <= ch_cnt;
                    Y_err <= 1'b0;
                    wrap  <= dwell_last && ch_last;
                end else begin
                    Y     <= sel_ok ? man_data : '0;
                    Y_sel <= Sel;
                    Y_err <= !sel_ok;
                end
            end else if (Y_ready) begin
                Y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nto1_scan.sv
// tb/tb_mux_nto1_scan.sv - scoreboard bench for mux_nto1_scan (N=4 and N=3 builds)
module tb_mux_nto1_scan;

    typedef struct {
        logic [7:0] y;
        logic [1:0] sel;
        logic       err;
        logic       wrap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] d_in = '0;
    logic [1:0]  sel = '0;
    logic        mode = 1'b0;
    logic        en = 1'b0;
    logic        ready = 1'b0;

    logic [7:0] y0, y1;
    logic [1:0] ys0, ys1;
    logic       v0, v1, e0, e1, w0, w1;

    int n_cmp = 0;
    int n_err = 0;

    int   NN [2] = '{4, 3};
    int   DWL[2] = '{2, 3};
    bit   mv [2];
    bit   last_cap [2];
    int   kc [2];
    logic [10:0] held [2];
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    mux_nto1_scan #(.N(4), .W(8), .DWELL(2)) u4 (
        .clk(clk), .rst_n(rst_n), .D(d_in), .Sel(sel), .mode(mode), .en(en),
        .Y(y0), .Y_sel(ys0), .Y_valid(v0), .Y_ready(ready), .Y_err(e0), .wrap(w0)
    );

    mux_nto1_scan #(.N(3), .W(8), .DWELL(3)) u3 (
        .clk(clk), .rst_n(rst_n), .D(d_in[23:0]), .Sel(sel), .mode(mode), .en(en),
        .Y(y1), .Y_sel(ys1), .Y_valid(v1), .Y_ready(ready), .Y_err(e1), .wrap(w1)
    );

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d t=%0t: got %h expected %h", name, inst, $time, act, exp);
        end
    endtask

    // Reference: scan sample number k (since entering scan) reads channel (k/DWELL) mod N;
    // wrap marks the sample that completes a full N*DWELL round
    task automatic model_step(input int i);
        exp_t        e;
        logic [31:0] t;
        int          c;
        bit          cap;
        if (!rst_n) begin
            mv[i] = 0; kc[i] = 0; last_cap[i] = 0;
            if (i == 0) q0.delete(); else q1.delete();
            return;
        end
        cap = en && (!mv[i] || ready);
        last_cap[i] = cap;
        if (cap) begin
            if (mode) begin
                c      = (kc[i] / DWL[i]) % NN[i];
                t      = d_in >> (c * 8);
                e.y    = t[7:0];
                e.sel  = 2'(c);
                e.err  = 1'b0;
                e.wrap = ((kc[i] + 1) % (NN[i] * DWL[i])) == 0;
                kc[i]++;
            end else if (int'(sel) < NN[i]) begin
                t      = d_in >> (int'(sel) * 8);
                e.y    = t[7:0];
                e.sel  = sel;
                e.err  = 1'b0;
                e.wrap = 1'b0;
            end else begin
                e.y    = 8'h00;
                e.sel  = sel;
                e.err  = 1'b1;
                e.wrap = 1'b0;
            end
            if (i == 0) q0.push_back(e); else q1.push_back(e);
            mv[i] = 1;
        end else if (ready) begin
            mv[i] = 0;
        end
        if (!(en && mode)) kc[i] = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic drive(input bit e_i, input bit m_i, input logic [1:0] s_i, input bit r_i, input logic [31:0] d_i);
        tick();
        en = e_i; mode = m_i; sel = s_i; ready = r_i; d_in = d_i;
    endtask

    task automatic mon(input int i, input logic [7:0] y, input logic [1:0] s,
                       input logic e, input logic w, input logic v);
        exp_t x;
        bit   have;
        chk("y_valid", i, 32'(v), 32'(mv[i]));
        if (last_cap[i]) begin
            have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (!have) begin
                chk("queue_underflow", i, 32'd1, 32'd0);
            end else begin
                x = (i == 0) ? q0.pop_front() : q1.pop_front();
                chk("y", i, 32'(y), 32'(x.y));
                chk("y_sel", i, 32'(s), 32'(x.sel));
                chk("y_err", i, 32'(e), 32'(x.err));
                chk("wrap", i, 32'(w), 32'(x.wrap));
                held[i] = {x.y, x.sel, x.err};
            end
        end else begin
            chk("wrap_quiet", i, 32'(w), 32'd0);
            if (v) chk("hold_stable", i, 32'({y, s, e}), 32'(held[i]));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                mon(0, y0, ys0, e0, w0, v0);
                mon(1, y1, ys1, e1, w1, v1);
            end
        end
    end

    initial begin
        logic [31:0] dr;
        bit          mr;
        // reset state
        #2;
        chk("reset_y", 0, 32'(y0), 0);
        chk("reset_valid", 0, 32'(v0), 0);
        chk("reset_valid", 1, 32'(v1), 0);
        @(negedge clk); #2;
        rst_n = 1'b1;

        // manual select 0..3, always ready
        for (int s = 0; s < 4; s++) drive(1, 0, 2'(s), 1, 32'h44332211);
        // back-to-back scan, 9 samples
        for (int c = 0; c < 9; c++) drive(1, 1, 2'd0, 1, 32'h44332211);
        // restart scan from idle, stall 3 cycles after the first sample
        drive(0, 0, 2'd0, 1, 32'h44332211);
        drive(1, 1, 2'd0, 1, 32'h44332211);
        for (int c = 0; c < 3; c++) drive(1, 1, 2'd0, 0, 32'h44332211);
        for (int c = 0; c < 3; c++) drive(1, 1, 2'd0, 1, 32'h44332211);
        // out-of-range select on the N=3 build, then a legal one
        drive(1, 0, 2'd3, 1, 32'h44332211);
        drive(1, 0, 2'd1, 1, 32'h44332211);
        // manual to scan switch mid-stream, with a stalled mode change
        drive(1, 0, 2'd3, 0, 32'h44332211);
        drive(1, 1, 2'd3, 0, 32'h55667788);
        for (int c = 0; c < 4; c++) drive(1, 1, 2'd0, 1, 32'h55667788);
        // idle with a pending sample, then drain
        drive(1, 0, 2'd2, 0, 32'h0A0B0C0D);
        drive(0, 0, 2'd0, 0, 32'h0A0B0C0D);
        drive(0, 0, 2'd0, 1, 32'h0A0B0C0D);

        // reset during scan while pointing at channel 2 of the N=4 build
        drive(0, 0, 2'd0, 1, 32'h44332211);
        for (int c = 0; c < 5; c++) drive(1, 1, 2'd0, 1, 32'h44332211);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_y", 0, 32'(y0), 0);
        chk("rst_sel", 0, 32'(ys0), 0);
        chk("rst_valid", 0, 32'(v0), 0);
        chk("rst_err", 0, 32'(e0), 0);
        chk("rst_wrap", 0, 32'(w0), 0);
        chk("rst_y", 1, 32'(y1), 0);
        chk("rst_valid", 1, 32'(v1), 0);
        tick();
        @(negedge clk); #2;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) drive(1, 1, 2'd0, 1, 32'h44332211);

        // randomized traffic
        mr = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 9) == 0) mr = ~mr;
            dr = $urandom;
            drive($urandom_range(0, 9) != 0, mr, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 9) < 7, dr);
        end

        // drain
        for (int c = 0; c < 4; c++) drive(0, 0, 2'd0, 1, 32'h0);
        tick();
        @(negedge clk); #1;
        chk("queue_empty", 0, 32'(q0.size()), 0);
        chk("queue_empty", 1, 32'(q1.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
